// File: rtl/shifter_pkg.sv
// Shared types and constants for the iterative shift unit.
package shifter_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_NOP = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shifter_state_t;

endpackage

// File: rtl/iterative_shifter_step.sv
// Combinational single-step shifter: shifts data_i by k_i (0..STEP) per op_i.
// SRA replicates the MSB of data_i, which is the latched operand sign because
// arithmetic shifts never change the top bit.
module shift_step
  import shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4,
  localparam int KW  = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [KW-1:0]   k_i,
  input  shift_op_t       op_i,
  output logic [XLEN-1:0] data_o
);

  // Select the shift flavour for this step.
  always_comb begin
    data_o = data_i;
    case (op_i)
      SHIFT_SLL: data_o = data_i << k_i;
      SHIFT_SRL: data_o = data_i >> k_i;
      SHIFT_SRA: data_o = $unsigned($signed(data_i) >>> k_i);
      default:   data_o = data_i;
    endcase
  end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle SLL/SRL/SRA unit shifting STEP bits per cycle.
// Optional busy-cycle counter enabled by defining SHIFTER_PERF_CNT_EN.
module iterative_shifter
  import shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [XLEN-1:0]    result,
  output logic               busy
`ifdef SHIFTER_PERF_CNT_EN
  ,
  output logic [31:0]        busy_cycles
`endif
);

  localparam int KW = $clog2(STEP + 1);
  localparam logic [SHAMT_W-1:0] STEP_R = SHAMT_W'(STEP);

  shifter_state_t     state_q, state_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  shift_op_t          op_q, op_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [KW-1:0]      step_k;
  logic [XLEN-1:0]    step_out;

  // Chunk size for this cycle: min(STEP, remaining).
  always_comb begin
    step_k = (rem_q > STEP_R) ? KW'(STEP) : KW'(rem_q);
  end

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_step (
    .data_i (result_q),
    .k_i    (step_k),
    .op_i   (op_q),
    .data_o (step_out)
  );

  // Next-state and datapath update; result_q doubles as the latched operand.
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          result_d = operand;
          op_d     = shift_op_t'(op);
          rem_d    = shamt;
          if (shamt == '0 || op == SHIFT_NOP) state_d = ST_DONE;
          else                                state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        result_d = step_out;
        rem_d    = rem_q - SHAMT_W'(step_k);
        if (rem_q <= STEP_R) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      op_q     <= SHIFT_NOP;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  assign start_ready  = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign result       = result_q;

`ifdef SHIFTER_PERF_CNT_EN
  logic [31:0] busy_cnt_q;

  // Saturating count of edges seen while busy; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                      busy_cnt_q <= '0;
    else if (busy && busy_cnt_q != '1) busy_cnt_q <= busy_cnt_q + 32'd1;
  end

  assign busy_cycles = busy_cnt_q;
`endif

endmodule
